// File: rtl/regfile_pkg.sv
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared definitions for the multi-port register file.
//                Holds the default widths, a constant-evaluable ceil(log2)
//                helper and the register-address type.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    // ceil(log2(value)). Usable in parameter expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int AW_DEF = clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

`default_nettype wire

// File: rtl/rf_scoreboard.sv
// ============================================================================
//  Module      : rf_scoreboard
//  Description : Per-register pending-write scoreboard. A bit is set by an
//                issue and cleared by any enabled write to the same register.
//                If both happen on the same edge, the issue wins because it
//                represents a newer producer. Register 0 is never busy.
//                busy_cnt_o is the registered population count of the vector.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk         clock, rising edge
//    rst         synchronous active-high reset
//    wr_en_i     write enables, one per write port
//    wr_addr_i   write addresses, port j in slice j
//    iss_en_i    issue strobe
//    iss_addr_i  register marked as pending by the issue
//    busy_o      current busy vector (bit 0 is always 0)
//    busy_cnt_o  number of busy registers
// ============================================================================
`default_nettype none

module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS = NREGS_DEF,
    parameter  int NWP   = 2,
    localparam int AW    = clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWP-1:0]    wr_en_i,
    input  logic [NWP*AW-1:0] wr_addr_i,
    input  logic              iss_en_i,
    input  logic [AW-1:0]     iss_addr_i,
    output logic [NREGS-1:0]  busy_o,
    output logic [AW:0]       busy_cnt_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      busy_cnt_q;
    logic [AW:0]      busy_cnt_d;

    always_comb begin
        busy_d = busy_q;
        // Clears first, then the set, so a same-edge issue overrides a write.
        for (int j = 0; j < NWP; j++) begin
            if (wr_en_i[j]) begin
                busy_d[wr_addr_i[j*AW +: AW]] = 1'b0;
            end
        end
        if (iss_en_i) begin
            busy_d[iss_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Count the next-state vector so the registered count tracks busy_q.
    always_comb begin
        busy_cnt_d = '0;
        for (int r = 0; r < NREGS; r++) begin
            busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_d[r]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_cnt_o = busy_cnt_q;

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
//  Module      : regfile_mp
//  Description : Parametrised multi-port integer register file with optional
//                same-cycle write-to-read bypass and a pending-write
//                scoreboard. Register 0 reads as zero and is never busy.
//                Write conflicts resolve to the highest write-port index.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk         clock, rising edge
//    rst         synchronous active-high reset
//    rd_addr_i   read addresses, port i in slice i
//    rd_data_o   read data (combinational)
//    rd_busy_o   addressed register has a pending write
//    wr_en_i     write enables
//    wr_addr_i   write addresses
//    wr_data_i   write data
//    iss_en_i    mark iss_addr_i as pending
//    iss_addr_i  register to mark
//    busy_cnt_o  registered count of busy registers
// ============================================================================
`default_nettype none

module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEF,
    parameter  int NREGS  = NREGS_DEF,
    parameter  int NRP    = 2,
    parameter  int NWP    = 2,
    parameter  int BYPASS = 1,
    localparam int AW     = clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRP*AW-1:0]   rd_addr_i,
    output logic [NRP*XLEN-1:0] rd_data_o,
    output logic [NRP-1:0]      rd_busy_o,
    input  logic [NWP-1:0]      wr_en_i,
    input  logic [NWP*AW-1:0]   wr_addr_i,
    input  logic [NWP*XLEN-1:0] wr_data_i,
    input  logic                iss_en_i,
    input  logic [AW-1:0]       iss_addr_i,
    output logic [AW:0]         busy_cnt_o
);

    logic [XLEN-1:0]  mem_q [NREGS];
    logic [XLEN-1:0]  mem_d [NREGS];
    logic [NREGS-1:0] busy;

    // Ascending port order: a later port overwrites an earlier one, giving
    // the highest index priority on address conflicts.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            mem_d[r] = mem_q[r];
        end
        for (int j = 0; j < NWP; j++) begin
            if (wr_en_i[j]) begin
                mem_d[wr_addr_i[j*AW +: AW]] = wr_data_i[j*XLEN +: XLEN];
            end
        end
        mem_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= mem_d[r];
            end
        end
    end

    for (genvar i = 0; i < NRP; i++) begin : g_rd
        logic [AW-1:0]   rd_addr;
        logic [XLEN-1:0] rd_val;
        logic            rd_hit;

        assign rd_addr = rd_addr_i[i*AW +: AW];

        always_comb begin
            rd_val = mem_q[rd_addr];
            rd_hit = 1'b0;
            if (BYPASS != 0) begin
                for (int j = 0; j < NWP; j++) begin
                    if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == rd_addr)) begin
                        rd_val = wr_data_i[j*XLEN +: XLEN];
                        rd_hit = 1'b1;
                    end
                end
            end
            if (rd_addr == '0) begin
                rd_val = '0;
                rd_hit = 1'b0;
            end
        end

        assign rd_data_o[i*XLEN +: XLEN] = rd_val;
        // A bypassed value is the result itself, so it is no longer pending.
        assign rd_busy_o[i] = busy[rd_addr] & ~rd_hit;
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NWP   (NWP)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .iss_en_i   (iss_en_i),
        .iss_addr_i (iss_addr_i),
        .busy_o     (busy),
        .busy_cnt_o (busy_cnt_o)
    );

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
//  Module      : tb_regfile_mp
//  Description : Self-checking bench for regfile_mp. Two instances share all
//                inputs, one with bypass and one without, and are compared
//                against an array-based reference of the register file.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_mp;
    import regfile_pkg::*;

    logic        clk;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        iss_en;
    reg_addr_t   iss_addr;

    logic [63:0] rd_data_b, rd_data_n;
    logic [1:0]  rd_busy_b, rd_busy_n;
    logic [5:0]  busy_cnt_b, busy_cnt_n;

    int n_vec;
    int n_err;

    // Reference state
    logic [31:0] m_reg  [32];
    bit          m_busy [32];

    regfile_mp #(.BYPASS(1)) u_byp (
        .clk(clk), .rst(rst),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data_b), .rd_busy_o(rd_busy_b),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .iss_en_i(iss_en), .iss_addr_i(iss_addr), .busy_cnt_o(busy_cnt_b)
    );

    regfile_mp #(.BYPASS(0)) u_nob (
        .clk(clk), .rst(rst),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data_n), .rd_busy_o(rd_busy_n),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .iss_en_i(iss_en), .iss_addr_i(iss_addr), .busy_cnt_o(busy_cnt_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Value a reader should see this cycle, given the current write inputs.
    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        logic [31:0] v;
        v = m_reg[a];
        if (byp) begin
            for (int j = 0; j < 2; j++) begin
                if (wr_en[j] && wr_addr[j*5 +: 5] == a) v = wr_data[j*32 +: 32];
            end
        end
        if (a == 5'd0) v = 32'd0;
        return v;
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input bit byp);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < 2; j++) begin
            if (wr_en[j] && wr_addr[j*5 +: 5] == a) hit = 1'b1;
        end
        if (a == 5'd0) return 1'b0;
        if (byp && hit) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic int exp_cnt();
        int c;
        c = 0;
        for (int r = 0; r < 32; r++) c += int'(m_busy[r]);
        return c;
    endfunction

    task automatic model_edge();
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_reg[r]  = 32'd0;
                m_busy[r] = 1'b0;
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (wr_en[j] && wr_addr[j*5 +: 5] != 5'd0) begin
                    m_reg[wr_addr[j*5 +: 5]]  = wr_data[j*32 +: 32];
                    m_busy[wr_addr[j*5 +: 5]] = 1'b0;
                end
            end
            if (iss_en && iss_addr != 5'd0) m_busy[iss_addr] = 1'b1;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rd_data_byp[%0d]", i), rd_data_b[i*32 +: 32], exp_rd(rd_addr[i*5 +: 5], 1'b1));
            chk($sformatf("rd_data_nob[%0d]", i), rd_data_n[i*32 +: 32], exp_rd(rd_addr[i*5 +: 5], 1'b0));
            chk($sformatf("rd_busy_byp[%0d]", i), {31'd0, rd_busy_b[i]}, {31'd0, exp_busy(rd_addr[i*5 +: 5], 1'b1)});
            chk($sformatf("rd_busy_nob[%0d]", i), {31'd0, rd_busy_n[i]}, {31'd0, exp_busy(rd_addr[i*5 +: 5], 1'b0)});
        end
        chk("busy_cnt_byp", {26'd0, busy_cnt_b}, exp_cnt());
        chk("busy_cnt_nob", {26'd0, busy_cnt_n}, exp_cnt());
    endtask

    // Inputs were driven just after the previous edge; check mid-cycle,
    // then advance the model across the edge.
    task automatic step();
        #4;
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rst     = 1'b0;
        wr_en   = 2'b00;
        wr_addr = '0;
        wr_data = '0;
        iss_en  = 1'b0;
        iss_addr = '0;
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
        wr_en[p]          = 1'b1;
        wr_addr[p*5 +: 5] = a;
        wr_data[p*32 +: 32] = d;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        idle();
        rd(5'd0, 5'd0);
        rst = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
        rst = 1'b0;

        // Reset state
        rd(5'd5, 5'd31);
        #4;
        chk("reset_rd_x5", rd_data_b[31:0], 32'd0);
        chk("reset_cnt", {26'd0, busy_cnt_b}, 32'd0);
        step();

        // Reset clears a written register
        idle(); wr(0, 5'd5, 32'hDEADBEEF); rd(5'd5, 5'd5);
        step();
        idle(); rd(5'd5, 5'd5);
        #4;
        chk("pre_reset_x5", rd_data_n[31:0], 32'hDEADBEEF);
        step();
        idle(); rst = 1'b1; rd(5'd5, 5'd5);
        step();
        idle(); rd(5'd5, 5'd5);
        #4;
        chk("post_reset_x5", rd_data_b[31:0], 32'd0);
        step();

        // x0 rules
        idle(); wr(0, 5'd0, 32'd1000); iss_en = 1'b1; iss_addr = 5'd0; rd(5'd0, 5'd0);
        step();
        idle(); rd(5'd0, 5'd0);
        #4;
        chk("x0_data", rd_data_b[31:0], 32'd0);
        chk("x0_cnt", {26'd0, busy_cnt_b}, 32'd0);
        step();

        // Bypass vs no bypass
        idle(); wr(0, 5'd3, 32'd100); rd(5'd3, 5'd3);
        #4;
        chk("bypass_same_cycle", rd_data_b[31:0], 32'd100);
        chk("nobypass_same_cycle", rd_data_n[31:0], 32'd0);
        step();
        idle(); rd(5'd3, 5'd0);
        #4;
        chk("nobypass_next_cycle", rd_data_n[31:0], 32'd100);
        step();

        // Write conflict
        idle(); wr(0, 5'd7, 32'd11); wr(1, 5'd7, 32'd22); rd(5'd7, 5'd7);
        step();
        idle(); rd(5'd7, 5'd7);
        #4;
        chk("conflict_x7", rd_data_n[63:32], 32'd22);
        step();

        // Scoreboard
        idle(); iss_en = 1'b1; iss_addr = 5'd4; rd(5'd4, 5'd9);
        step();
        idle(); iss_en = 1'b1; iss_addr = 5'd9; rd(5'd4, 5'd9);
        #4;
        chk("sb_cnt1", {26'd0, busy_cnt_b}, 32'd1);
        step();
        idle(); wr(1, 5'd4, 32'd44); rd(5'd4, 5'd9);
        #4;
        chk("sb_cnt2", {26'd0, busy_cnt_b}, 32'd2);
        step();
        idle(); wr(0, 5'd9, 32'd99); iss_en = 1'b1; iss_addr = 5'd9; rd(5'd4, 5'd9);
        #4;
        chk("sb_x4_free", {31'd0, rd_busy_n[0]}, 32'd0);
        chk("sb_cnt_after_wr", {26'd0, busy_cnt_b}, 32'd1);
        step();
        idle(); rd(5'd9, 5'd9);
        #4;
        chk("sb_x9_busy", {31'd0, rd_busy_b[0]}, 32'd1);
        chk("sb_cnt_iss_wr", {26'd0, busy_cnt_b}, 32'd1);
        step();

        // Reset priority
        idle(); rst = 1'b1; wr(0, 5'd2, 32'd55); iss_en = 1'b1; iss_addr = 5'd2; rd(5'd2, 5'd2);
        step();
        idle(); rd(5'd2, 5'd2);
        #4;
        chk("rstprio_x2", rd_data_n[31:0], 32'd0);
        chk("rstprio_busy", {31'd0, rd_busy_n[0]}, 32'd0);
        chk("rstprio_cnt", {26'd0, busy_cnt_n}, 32'd0);
        step();

        // Random traffic; small address pool half the time to force conflicts
        for (int k = 0; k < 400; k++) begin
            idle();
            rst = ($urandom_range(0, 59) == 0);
            for (int j = 0; j < 2; j++) begin
                wr_en[j] = ($urandom_range(0, 2) != 0);
                wr_addr[j*5 +: 5] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
                wr_data[j*32 +: 32] = $urandom;
            end
            iss_en   = ($urandom_range(0, 1) != 0);
            iss_addr = 5'($urandom_range(0, 31));
            rd_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
